uart_xcvr: RTL and testbench
============================

UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-002 Parameter FIFO_DEPTH, default 16: entries in each of the TX and RX FIFOs; must be a power of 2 and at least 2.
REQ-003 Parameter DIV_WIDTH, default 16: width of the baud divisor.
REQ-004 The clock and reset ports SHALL be: wb_clk_i  in  1  single clock; wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 The configuration ports SHALL be: clk_div  in  DIV_WIDTH  bit period = clk_div+1 clocks, legal >= 3; parity_en  in  1  parity bit enable; parity_odd  in  1  1 = odd parity, 0 = even; stop2  in  1  1 = two stop bits.
REQ-006 The TX user ports SHALL be: tx_valid  in  1  push request; tx_data  in  DATA_BITS  data to send; tx_ready  out  1  TX FIFO not full.
REQ-007 The RX user ports SHALL be: rx_valid  out  1  RX FIFO not empty; rx_data  out  DATA_BITS  head entry; rx_perr  out  1  parity error flag of the head entry; rx_ferr  out  1  framing error flag of the head entry; rx_ready  in  1  pop request.
REQ-008 The status ports SHALL be: rx_overrun  out  1  sticky overrun flag; err_clr  in  1  clears rx_overrun; tx_busy  out  1  TX activity; tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy; rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
REQ-009 The serial ports SHALL be: ser_tx  out  1  serial line, idle high; ser_rx  in  1  asynchronous serial input.

Function
REQ-010 A TX push SHALL be accepted on any rising edge where tx_valid and tx_ready are both 1; an RX pop SHALL occur on any edge where rx_valid and rx_ready are both 1.
REQ-011 The TX FSM SHALL use the states IDLE, START, DATA, PARITY, STOP1, STOP2.
- Each state except IDLE SHALL last exactly clk_div+1 clocks.
- PARITY SHALL be skipped when parity_en=0.
- STOP2 SHALL be skipped when stop2=0.
REQ-012 In IDLE with the TX FIFO non-empty, the TX FSM SHALL pop one entry and enter START on the same edge.
- When the FIFO was empty and a push is accepted at edge N, ser_tx SHALL go low after edge N+1.
REQ-013 DATA SHALL shift DATA_BITS bits out LSB first; the parity bit SHALL be the XOR of the data bits, inverted when parity_odd=1.
REQ-014 From the last stop bit with the TX FIFO non-empty, the TX FSM SHALL go directly to START with no idle gap.
REQ-015 clk_div, parity_en, parity_odd and stop2 SHALL be latched at frame start, in both TX and RX; changes mid-frame SHALL NOT affect the current frame.
REQ-016 tx_busy SHALL be 1 when the TX FSM is not in IDLE or the TX FIFO is non-empty.
REQ-017 ser_rx SHALL pass through a 2-flop synchroniser before any use.
REQ-018 The RX FSM SHALL use the states IDLE, START, DATA, PARITY, STOP.
- A falling edge of the synchronised input in IDLE SHALL enter START.
- At floor((clk_div+1)/2) clocks the line SHALL be resampled; if high, the FSM SHALL return to IDLE (glitch reject) and no entry SHALL be written.
- Subsequent bits SHALL be sampled every clk_div+1 clocks at bit centre.
REQ-019 The RX FSM SHALL check only the first stop bit and SHALL return to IDLE immediately after sampling it.
- rx_ferr SHALL be set when the sampled stop bit is 0.
- rx_perr SHALL be set when parity_en=1 and the received parity mismatches.
- Data and both flags SHALL be written to the RX FIFO as one entry.
REQ-020 When the RX FIFO is full at the write edge and no pop occurs on that edge, the frame SHALL be dropped and rx_overrun SHALL be set.
- A pop on the same edge SHALL free the slot, and the write SHALL succeed.
REQ-021 err_clr SHALL clear rx_overrun; if err_clr and a new overrun occur on the same edge, rx_overrun SHALL stay 1.
REQ-022 On a simultaneous push and pop on the same FIFO, the level SHALL stay unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-023 Asserting wb_rst_i SHALL asynchronously force the following, including mid-frame (the partial frame is discarded):
- both FSMs to IDLE;
- both FIFOs to empty;
- ser_tx=1, tx_ready=1, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, rx_overrun=0, tx_busy=0, tx_level=0, rx_level=0;
- synchroniser flops to 1.

Structure
REQ-024 A shared package uart_pkg SHALL hold the TX/RX state enums and the default parameter constants.
REQ-025 Sub-module uart_fifo, a parametrised synchronous FIFO with width, depth and level output, SHALL be instantiated twice: TX width DATA_BITS, RX width DATA_BITS+2.

Verification
REQ-026 With clk_div=9, 8N1, push 0x3D: ser_tx SHALL be low for 10 clocks, then 1,0,1,1,1,1,0,0 for 10 clocks each, then high for 10 clocks; tx_busy SHALL be 0 afterwards.
REQ-027 Push 0xA5 and 0x5A back-to-back with parity_en=1, parity_odd=1, stop2=1: the frames SHALL be 12 bits each with parity bits 1 and 1, and there SHALL be no idle gap between the frames.
REQ-028 Loop ser_tx to ser_rx and send 16 random bytes: rx_data SHALL match all 16 in order with rx_perr=0 and rx_ferr=0; rx_level SHALL reach 16.
REQ-029 Drive 17 frames into ser_rx with rx_ready=0 and FIFO_DEPTH=16: rx_overrun=1 and rx_level=16, and the 17th byte SHALL be absent; err_clr SHALL clear rx_overrun.
REQ-030 Drive a 3-clock low glitch on ser_rx with clk_div=15: no entry SHALL be written; a frame with stop bit 0 SHALL produce rx_ferr=1.
REQ-031 Assert wb_rst_i mid-frame during TX of 0xFF: ser_tx=1 immediately and tx_level=0; after reset release, a fresh push SHALL transmit correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and default parameters for the UART transceiver
package uart_pkg;

   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_FIFO_DEPTH = 16;
   localparam int DEF_DIV_WIDTH  = 16;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP1,
      TX_STOP2
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with occupancy level; head reads as zero when empty
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_level   = r_level;
   assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_wdata;
   end

endmodule

// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - UART transceiver with TX/RX FIFOs, programmable divisor, parity and stop bits
module uart_xcvr
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic [DIV_WIDTH-1:0]          clk_div,
   input  logic                          parity_en,
   input  logic                          parity_odd,
   input  logic                          stop2,
   input  logic                          tx_valid,
   input  logic [DATA_BITS-1:0]          tx_data,
   output logic                          tx_ready,
   output logic                          rx_valid,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_perr,
   output logic                          rx_ferr,
   input  logic                          rx_ready,
   output logic                          rx_overrun,
   input  logic                          err_clr,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          ser_tx,
   input  logic                          ser_rx
);

   // ---------------- TX path ----------------
   tx_state_t              r_tx_state;
   logic [DIV_WIDTH-1:0]   r_tx_cnt;
   logic [DIV_WIDTH-1:0]   r_tx_div;
   logic [DATA_BITS-1:0]   r_tx_shift;
   logic [2:0]             r_tx_bitn;
   logic                   r_tx_par;
   logic                   r_tx_pen;
   logic                   r_tx_stop2;
   logic                   r_ser_tx;

   logic [DATA_BITS-1:0]   w_tx_head;
   logic                   w_tx_full;
   logic                   w_tx_empty;
   logic                   w_tx_push;
   logic                   w_tx_pop;
   logic                   w_tx_bit_end;
   logic                   w_tx_last_stop;

   assign tx_ready       = !w_tx_full;
   assign w_tx_push      = tx_valid && !w_tx_full;
   assign w_tx_bit_end   = (r_tx_cnt == r_tx_div);
   assign w_tx_last_stop = w_tx_bit_end &&
                           ((r_tx_state == TX_STOP1 && !r_tx_stop2) || r_tx_state == TX_STOP2);
   // Popping at the end of the last stop bit chains frames with no idle gap.
   assign w_tx_pop       = !w_tx_empty && (r_tx_state == TX_IDLE || w_tx_last_stop);
   assign tx_busy        = (r_tx_state != TX_IDLE) || !w_tx_empty;
   assign ser_tx         = r_ser_tx;

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clk   (wb_clk_i),
      .i_rst   (wb_rst_i),
      .i_push  (w_tx_push),
      .i_wdata (tx_data),
      .i_pop   (w_tx_pop),
      .o_rdata (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_level (tx_level)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_div   <= '0;
         r_tx_shift <= '0;
         r_tx_bitn  <= '0;
         r_tx_par   <= 1'b0;
         r_tx_pen   <= 1'b0;
         r_tx_stop2 <= 1'b0;
         r_ser_tx   <= 1'b1;
      end else if (w_tx_pop) begin
         r_tx_state <= TX_START;
         r_tx_cnt   <= '0;
         r_tx_div   <= clk_div;
         r_tx_pen   <= parity_en;
         r_tx_stop2 <= stop2;
         r_tx_shift <= w_tx_head;
         r_tx_par   <= (^w_tx_head) ^ parity_odd;
         r_ser_tx   <= 1'b0;
      end else if (r_tx_state != TX_IDLE) begin
         if (!w_tx_bit_end) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
         end else begin
            r_tx_cnt <= '0;
            case (r_tx_state)
               TX_START: begin
                  r_tx_state <= TX_DATA;
                  r_tx_bitn  <= '0;
                  r_ser_tx   <= r_tx_shift[0];
                  r_tx_shift <= r_tx_shift >> 1;
               end
               TX_DATA: begin
                  if (r_tx_bitn == 3'(DATA_BITS-1)) begin
                     r_tx_state <= r_tx_pen ? TX_PARITY : TX_STOP1;
                     r_ser_tx   <= r_tx_pen ? r_tx_par : 1'b1;
                  end else begin
                     r_tx_bitn  <= r_tx_bitn + 1'b1;
                     r_ser_tx   <= r_tx_shift[0];
                     r_tx_shift <= r_tx_shift >> 1;
                  end
               end
               TX_PARITY: begin
                  r_tx_state <= TX_STOP1;
                  r_ser_tx   <= 1'b1;
               end
               TX_STOP1: begin
                  r_tx_state <= r_tx_stop2 ? TX_STOP2 : TX_IDLE;
                  r_ser_tx   <= 1'b1;
               end
               default: begin
                  r_tx_state <= TX_IDLE;
                  r_ser_tx   <= 1'b1;
               end
            endcase
         end
      end
   end

   // ---------------- RX path ----------------
   rx_state_t              r_rx_state;
   logic [1:0]             r_sync;
   logic                   r_rx_prev;
   logic [DIV_WIDTH-1:0]   r_rx_cnt;
   logic [DIV_WIDTH-1:0]   r_rx_div;
   logic [DIV_WIDTH:0]     r_rx_hm1;
   logic                   r_rx_pen;
   logic                   r_rx_podd;
   logic [DATA_BITS-1:0]   r_rx_shift;
   logic [2:0]             r_rx_bitn;
   logic                   r_rx_perr;
   logic                   r_rx_wr;
   logic [DATA_BITS+1:0]   r_rx_wdata;
   logic                   r_overrun;

   logic                   w_rx_s;
   logic                   w_rx_fall;
   logic                   w_rx_bit_end;
   logic [DIV_WIDTH:0]     w_rx_half;
   logic [DATA_BITS+1:0]   w_rx_head;
   logic                   w_rx_full;
   logic                   w_rx_empty;
   logic                   w_rx_pop;
   logic                   w_rx_ovr;

   assign w_rx_s       = r_sync[1];
   assign w_rx_fall    = r_rx_prev && !w_rx_s;
   assign w_rx_bit_end = (r_rx_cnt == r_rx_div);
   assign w_rx_half    = ({1'b0, clk_div} + 1'b1) >> 1;
   assign rx_valid     = !w_rx_empty;
   assign rx_data      = w_rx_head[DATA_BITS-1:0];
   assign rx_perr      = w_rx_head[DATA_BITS];
   assign rx_ferr      = w_rx_head[DATA_BITS+1];
   assign w_rx_pop     = rx_ready && !w_rx_empty;
   assign w_rx_ovr     = r_rx_wr && w_rx_full && !w_rx_pop;
   assign rx_overrun   = r_overrun;

   uart_fifo #(.WIDTH(DATA_BITS+2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .i_clk   (wb_clk_i),
      .i_rst   (wb_rst_i),
      .i_push  (r_rx_wr),
      .i_wdata (r_rx_wdata),
      .i_pop   (w_rx_pop),
      .o_rdata (w_rx_head),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_level (rx_level)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_sync    <= 2'b11;
         r_rx_prev <= 1'b1;
         r_overrun <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], ser_rx};
         r_rx_prev <= w_rx_s;
         if (w_rx_ovr)     r_overrun <= 1'b1;
         else if (err_clr) r_overrun <= 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_div   <= '0;
         r_rx_hm1   <= '0;
         r_rx_pen   <= 1'b0;
         r_rx_podd  <= 1'b0;
         r_rx_shift <= '0;
         r_rx_bitn  <= '0;
         r_rx_perr  <= 1'b0;
         r_rx_wr    <= 1'b0;
         r_rx_wdata <= '0;
      end else begin
         r_rx_wr <= 1'b0;
         case (r_rx_state)
            RX_IDLE: begin
               if (w_rx_fall) begin
                  r_rx_state <= RX_START;
                  r_rx_cnt   <= '0;
                  r_rx_div   <= clk_div;
                  r_rx_hm1   <= w_rx_half - 1'b1;
                  r_rx_pen   <= parity_en;
                  r_rx_podd  <= parity_odd;
                  r_rx_perr  <= 1'b0;
               end
            end
            RX_START: begin
               // Mid start bit: a line back high means a glitch, not a frame.
               if ({1'b0, r_rx_cnt} == r_rx_hm1) begin
                  r_rx_cnt   <= '0;
                  r_rx_bitn  <= '0;
                  r_rx_state <= w_rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (w_rx_bit_end) begin
                  r_rx_cnt   <= '0;
                  r_rx_shift <= {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
                  if (r_rx_bitn == 3'(DATA_BITS-1))
                     r_rx_state <= r_rx_pen ? RX_PARITY : RX_STOP;
                  else
                     r_rx_bitn <= r_rx_bitn + 1'b1;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            RX_PARITY: begin
               if (w_rx_bit_end) begin
                  r_rx_cnt   <= '0;
                  r_rx_perr  <= ((^r_rx_shift) ^ r_rx_podd) != w_rx_s;
                  r_rx_state <= RX_STOP;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (w_rx_bit_end) begin
                  r_rx_cnt   <= '0;
                  r_rx_wr    <= 1'b1;
                  r_rx_wdata <= {~w_rx_s, r_rx_perr, r_rx_shift};
                  r_rx_state <= RX_IDLE;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - scoreboard bench for uart_xcvr: TX waveforms, loopback, overrun, errors, reset
module tb_uart_xcvr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] clk_div = 16'd9;
   logic        parity_en = 1'b0;
   logic        parity_odd = 1'b0;
   logic        stop2 = 1'b0;
   logic        tx_valid = 1'b0;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_ready;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_perr;
   logic        rx_ferr;
   logic        rx_ready = 1'b0;
   logic        rx_overrun;
   logic        err_clr = 1'b0;
   logic        tx_busy;
   logic [4:0]  tx_level;
   logic [4:0]  rx_level;
   logic        ser_tx;
   logic        ser_rx;
   logic        tb_rx = 1'b1;
   logic        loop_en = 1'b0;

   int          n_checks = 0;
   int          n_err = 0;
   logic [9:0]  exp_q [$];
   logic [9:0]  mon_exp;
   logic [7:0]  lb_tab [16] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3D, 8'hC3,
                                8'h7E, 8'h81, 8'h12, 8'h34, 8'hE7, 8'h0F, 8'hF0, 8'h99};

   assign ser_rx = loop_en ? ser_tx : tb_rx;

   always #5 clk = ~clk;

   uart_xcvr dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .clk_div    (clk_div),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop2      (stop2),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_perr    (rx_perr),
      .rx_ferr    (rx_ferr),
      .rx_ready   (rx_ready),
      .rx_overrun (rx_overrun),
      .err_clr    (err_clr),
      .tx_busy    (tx_busy),
      .tx_level   (tx_level),
      .rx_level   (rx_level),
      .ser_tx     (ser_tx),
      .ser_rx     (ser_rx)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tx(input logic [7:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      step();
      tx_valid = 1'b0;
   endtask

   // bits[i] is the i-th bit on the line; every clock of every bit period is checked.
   task automatic tx_frame(input string nm, input logic [11:0] bits, input int nb);
      for (int i = 0; i < nb; i++) begin
         for (int k = 0; k <= int'(clk_div); k++) begin
            @(negedge clk);
            chk(nm, 32'(ser_tx), 32'(bits[i]));
         end
      end
   endtask

   task automatic drive_bit(input logic b);
      tb_rx = b;
      repeat (int'(clk_div) + 1) step();
   endtask

   task automatic rx_drive(input logic [7:0] d, input logic use_par, input logic par_bit,
                           input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (use_par) drive_bit(par_bit);
      drive_bit(stop_bit);
      drive_bit(1'b1);
   endtask

   task automatic drain(input string nm);
      rx_ready = 1'b1;
      for (int i = 0; i < 3000 && (exp_q.size() != 0 || rx_valid); i++) step();
      rx_ready = 1'b0;
      chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      chk({nm, "_rx_valid"}, 32'(rx_valid), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && rx_valid && rx_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL rx_unexpected: got %0h required no entry at %0t",
                     {rx_ferr, rx_perr, rx_data}, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("rx_entry", 32'({rx_ferr, rx_perr, rx_data}), 32'(mon_exp));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ser_tx",   32'(ser_tx),     32'd1);
      chk("rst_tx_ready", 32'(tx_ready),   32'd1);
      chk("rst_rx_valid", 32'(rx_valid),   32'd0);
      chk("rst_rx_data",  32'(rx_data),    32'd0);
      chk("rst_flags",    32'({rx_perr, rx_ferr, rx_overrun}), 32'd0);
      chk("rst_tx_busy",  32'(tx_busy),    32'd0);
      chk("rst_levels",   32'({tx_level, rx_level}), 32'd0);
      rst = 1'b0;
      step();

      // 8N1, 0x3D
      push_tx(8'h3D);
      chk("busy_after_push",  32'(tx_busy),  32'd1);
      chk("level_after_push", 32'(tx_level), 32'd1);
      step();
      chk("level_after_pop",  32'(tx_level), 32'd0);
      tx_frame("frame_3d", 12'({1'b1, 8'h3D, 1'b0}), 10);
      step();
      chk("idle_after_3d_busy", 32'(tx_busy), 32'd0);
      chk("idle_after_3d_line", 32'(ser_tx),  32'd1);

      // 8O2 back-to-back
      parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1;
      tx_valid = 1'b1; tx_data = 8'hA5;
      step();
      tx_data = 8'h5A;
      step();
      tx_valid = 1'b0;
      tx_frame("frame_a5", {2'b11, 1'b1, 8'hA5, 1'b0}, 12);
      tx_frame("frame_5a", {2'b11, 1'b1, 8'h5A, 1'b0}, 12);
      step();
      chk("idle_after_8o2", 32'(tx_busy), 32'd0);
      parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;

      // loopback of 16 bytes
      loop_en = 1'b1;
      tx_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tx_data = lb_tab[i];
         exp_q.push_back({2'b00, lb_tab[i]});
         step();
      end
      tx_valid = 1'b0;
      for (int i = 0; i < 3000 && rx_level != 5'd16; i++) step();
      chk("loop_rx_level", 32'(rx_level),   32'd16);
      chk("loop_overrun",  32'(rx_overrun), 32'd0);
      drain("loop_drain");
      for (int i = 0; i < 300 && tx_busy; i++) step();
      loop_en = 1'b0;

      // 17 frames into a 16-deep RX FIFO
      for (int i = 0; i < 17; i++) begin
         logic [7:0] b;
         b = 8'(16 + i);
         if (i < 16) exp_q.push_back({2'b00, b});
         rx_drive(b, 1'b0, 1'b0, 1'b1);
      end
      chk("ovr_flag",  32'(rx_overrun), 32'd1);
      chk("ovr_level", 32'(rx_level),   32'd16);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("ovr_cleared", 32'(rx_overrun), 32'd0);
      drain("ovr_drain");

      // glitch reject, framing and parity errors at clk_div=15
      clk_div = 16'd15;
      rx_ready = 1'b1;
      tb_rx = 1'b0;
      repeat (3) step();
      tb_rx = 1'b1;
      repeat (40) step();
      chk("glitch_rx_level", 32'(rx_level), 32'd0);
      chk("glitch_rx_valid", 32'(rx_valid), 32'd0);
      exp_q.push_back({2'b10, 8'h81});
      rx_drive(8'h81, 1'b0, 1'b0, 1'b0);
      parity_en = 1'b1;
      exp_q.push_back({2'b01, 8'h0F});
      rx_drive(8'h0F, 1'b1, 1'b1, 1'b1);
      parity_odd = 1'b1;
      exp_q.push_back({2'b00, 8'h0F});
      rx_drive(8'h0F, 1'b1, 1'b1, 1'b1);
      drain("err_drain");
      parity_en = 1'b0; parity_odd = 1'b0;
      clk_div = 16'd9;

      // reset mid-frame
      tx_valid = 1'b1; tx_data = 8'hFF;
      step();
      step();
      tx_valid = 1'b0;
      repeat (4) step();
      chk("mid_start_low", 32'(ser_tx),   32'd0);
      chk("mid_tx_level",  32'(tx_level), 32'd1);
      rst = 1'b1;
      #2;
      chk("arst_ser_tx",   32'(ser_tx),   32'd1);
      chk("arst_tx_level", 32'(tx_level), 32'd0);
      chk("arst_tx_busy",  32'(tx_busy),  32'd0);
      chk("arst_tx_ready", 32'(tx_ready), 32'd1);
      step();
      rst = 1'b0;
      step();
      push_tx(8'h3D);
      step();
      tx_frame("frame_post_rst", 12'({1'b1, 8'h3D, 1'b0}), 10);
      step();
      chk("post_rst_idle", 32'(tx_busy), 32'd0);
      chk("final_queue",   32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
